// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-high glyphs and {g..a} bit positions.
package seg7_pkg;

    localparam int SEG_A_BIT = 0;
    localparam int SEG_B_BIT = 1;
    localparam int SEG_C_BIT = 2;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 4;
    localparam int SEG_F_BIT = 5;
    localparam int SEG_G_BIT = 6;

    // Glyphs are {g,f,e,d,c,b,a}, 1 = segment lit.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high {g..a} segment decoder with blank override.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (nibble)
                4'h0: seg = SEG_0;
                4'h1: seg = SEG_1;
                4'h2: seg = SEG_2;
                4'h3: seg = SEG_3;
                4'h4: seg = SEG_4;
                4'h5: seg = SEG_5;
                4'h6: seg = SEG_6;
                4'h7: seg = SEG_7;
                4'h8: seg = SEG_8;
                4'h9: seg = SEG_9;
                4'hA: seg = SEG_A;
                4'hB: seg = SEG_B;
                4'hC: seg = SEG_C;
                4'hD: seg = SEG_D;
                4'hE: seg = SEG_E;
                default: seg = SEG_F;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scanner with frame-synchronous, tear-free value capture.
// Define SEG7_SCAN_LZB_EN to enable leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int REFRESH_DIV    = 100000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int EN_ACTIVE_LOW  = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [4*DIGITS-1:0]   Value,
    input  logic                  Load,
    output logic [6:0]            out7,
    output logic [DIGITS-1:0]     en_out,
    output logic                  FrameTick
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [PW-1:0]     PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] EN_ONE   = DIGITS'(1);
    localparam logic [6:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] EN_OFF   = (EN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [PW-1:0]       pre;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       idx_nxt;
    logic [4*DIGITS-1:0] disp;
    logic [4*DIGITS-1:0] disp_nxt;
    logic [4*DIGITS-1:0] pend;
    logic                pend_v;
    logic                terminal;
    logic                wrap;
    logic [3:0]          nibble;
    logic                blank;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   en_hot;

    assign terminal = (pre == PRE_LAST);
    assign wrap     = terminal && (idx == IDX_LAST);
    assign idx_nxt  = terminal ? (wrap ? '0 : idx + 1'b1) : idx;

    // A Load on the boundary cycle bypasses the pending buffer.
    always_comb begin
        disp_nxt = disp;
        if (wrap) begin
            if (Load)
                disp_nxt = Value;
            else if (pend_v)
                disp_nxt = pend;
        end
    end

    assign nibble = disp_nxt[{idx_nxt, 2'b00} +: 4];
    assign en_hot = EN_ONE << idx_nxt;

`ifdef SEG7_SCAN_LZB_EN
    logic [DIGITS-1:0] lead_zero;

    // lead_zero[k]: nibble k and every nibble above it are zero.
    always_comb begin
        lead_zero = '0;
        for (int k = 0; k < DIGITS; k++)
            lead_zero[k] = ((disp_nxt >> (4 * k)) == '0);
    end

    assign blank = lead_zero[idx_nxt] && (idx_nxt != '0);
`else
    assign blank = 1'b0;
`endif

    seg7_hex_decode u_decode (
        .nibble (nibble),
        .blank  (blank),
        .seg    (seg)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pre       <= '0;
            idx       <= '0;
            disp      <= '0;
            pend      <= '0;
            pend_v    <= 1'b0;
            FrameTick <= 1'b0;
            out7      <= SEG_OFF;
            en_out    <= EN_OFF;
        end else begin
            pre       <= terminal ? '0 : pre + 1'b1;
            idx       <= idx_nxt;
            disp      <= disp_nxt;
            if (Load)
                pend <= Value;
            if (wrap)
                pend_v <= 1'b0;
            else if (Load)
                pend_v <= 1'b1;
            FrameTick <= wrap;
            out7      <= (SEG_ACTIVE_LOW != 0) ? ~seg : seg;
            en_out    <= (EN_ACTIVE_LOW != 0) ? ~en_hot : en_hot;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised self-checking bench for seg7_scan_driver (4 digits, 4-cycle dwell, active-low outputs).
module tb_seg7_scan_driver;

    localparam int D  = 4;
    localparam int RD = 4;
    localparam int FR = D * RD;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Load = 1'b0;
    logic [15:0] Value = 16'h0;
    logic [6:0]  out7;
    logic [3:0]  en_out;
    logic        FrameTick;

    seg7_scan_driver #(
        .DIGITS         (D),
        .REFRESH_DIV    (RD),
        .SEG_ACTIVE_LOW (1),
        .EN_ACTIVE_LOW  (1)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Value     (Value),
        .Load      (Load),
        .out7      (out7),
        .en_out    (en_out),
        .FrameTick (FrameTick)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: edges since reset release, shown word, pending word.
    int          t = 0;
    logic [15:0] m_disp = 16'h0;
    logic [15:0] m_pend = 16'h0;
    bit          m_pv = 1'b0;

    // Active-low glyphs 0..F.
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int d);
        logic [3:0] nib;
        int hi;
        nib = m_disp[4*d +: 4];
        hi = 0;
        for (int k = 0; k < D; k++)
            if (m_disp[4*k +: 4] != 4'h0) hi = k;
`ifdef SEG7_SCAN_LZB_EN
        if (d > hi) return 7'h7F;
`endif
        return glyph[nib];
    endfunction

    task automatic step(input bit ld, input logic [15:0] v);
        int d;
        bit bnd;
        Load  = ld;
        Value = v;
        @(posedge Clk);
        t++;
        bnd = (t % FR) == 0;
        if (bnd) begin
            if (ld) m_disp = v;
            else if (m_pv) m_disp = m_pend;
            m_pv = 1'b0;
        end else if (ld) begin
            m_pend = v;
            m_pv = 1'b1;
        end
        @(negedge Clk);
        Load  = 1'b0;
        Value = 16'($urandom);
        d = (t / RD) % D;
        check("en_out", en_out, 4'hF ^ (4'b0001 << d));
        check("out7", out7, exp_seg(d));
        check("frametick", FrameTick, bnd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0);
    endtask

    task automatic to_boundary_cycle;
        while (((t + 1) % FR) != 0) step(1'b0, 16'h0);
    endtask

    task automatic check_off(input string tag);
        check({tag, "_out7"}, out7, 7'h7F);
        check({tag, "_en"}, en_out, 4'hF);
        check({tag, "_ft"}, FrameTick, 1'b0);
    endtask

    task automatic release_reset;
        Reset  = 1'b1;
        t      = 0;
        m_disp = 16'h0;
        m_pend = 16'h0;
        m_pv   = 1'b0;
    endtask

    initial begin
        // Power-on reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check_off("reset");
        end
        release_reset();
        idle(40);

        // Load while digit 2 is active: must wait for the frame boundary.
        while (((t / RD) % D) != 2) step(1'b0, 16'h0);
        step(1'b1, 16'h12AF);
        idle(24);

        // Load exactly on the boundary cycle takes effect next cycle.
        to_boundary_cycle();
        step(1'b1, 16'h0005);
        idle(16);

        // Two loads in one frame: last one wins.
        while ((t % FR) != 1) step(1'b0, 16'h0);
        step(1'b1, 16'h1111);
        idle(3);
        step(1'b1, 16'h2222);
        idle(36);

        // Mid-frame asynchronous reset after showing BEEF.
        to_boundary_cycle();
        step(1'b1, 16'hBEEF);
        while (((t / RD) % D) != 1) step(1'b0, 16'h0);
        #2 Reset = 1'b0;
        #1 check_off("async_reset");
        @(negedge Clk);
        check_off("async_hold");
        release_reset();
        idle(20);

        // Leading-zero pattern.
        to_boundary_cycle();
        step(1'b1, 16'h0030);
        idle(20);

        // Random loads and values.
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 9) == 0, 16'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised time-multiplexed seven-segment display driver for the CPU top level. Replaces the fixed 8-digit scanner that drives `out7`/`en_out`. Captures a packed hex word from the datapath (PC, `s0`, `v0`/`v1` debug values), holds it in a tear-free shadow register, and scans it across `DIGITS` common-anode digits at a programmable refresh rate. Adds frame-synchronous update, configurable output polarity, and an optional leading-zero blanking mode.

## Interface
- `DIGITS`, 8: number of digits scanned; legal range 2..16.
- `REFRESH_DIV`, 100000: `Clk` cycles each digit stays enabled; minimum 2.
- `SEG_ACTIVE_LOW`, 1: 1 = segment lit when its `out7` bit is 0.
- `EN_ACTIVE_LOW`, 1: 1 = digit enabled when its `en_out` bit is 0.

Ports:
- `Clk`  in  1  sole clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Value`  in  4*DIGITS  hex nibbles; nibble k (`Value[4k+3:4k]`) drives digit k; digit 0 is rightmost.
- `Load`  in  1  single-cycle strobe that captures `Value`.
- `out7`  out  7  segment drive `{g,f,e,d,c,b,a}`, registered.
- `en_out`  out  DIGITS  one-hot digit enable, registered.
- `FrameTick`  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

## Operation
- Prescaler `pre`: counts 0..REFRESH_DIV-1, then wraps. Terminal count is `pre == REFRESH_DIV-1`.
- Digit index `idx`: advances on each terminal count. Wraps from DIGITS-1 to 0; that wrap is the frame boundary.
- Capture path:
  - `Load` copies `Value` into `pend` and sets `pend_v`.
  - At the frame boundary, if `pend_v` is set, `disp <= pend` and `pend_v` clears.
  - If `Load` coincides with the frame boundary, `disp <= Value` directly and `pend_v` stays clear.
  - When several `Load` strobes arrive within one frame, the last one wins.
- Output stage:
  - `out7 <= decode(disp nibble idx)`.
  - `en_out <=` one-hot of `idx`.
  - Both are computed from the post-update `idx`/`disp`.
  - Both are inverted per `SEG_ACTIVE_LOW`/`EN_ACTIVE_LOW`.
- Decode is standard hex: 0 = a,b,c,d,e,f; 1 = b,c; … ; A, b, C, d, E, F in conventional glyphs.
- Reset (async, any time, including mid-frame) forces:
  - `pre = 0`, `idx = 0`, `disp = 0`, `pend = 0`, `pend_v = 0`, `FrameTick = 0`.
  - `out7` all segments off: 7'h7F if `SEG_ACTIVE_LOW`, else 7'h00.
  - `en_out` all digits off.

  After reset deasserts, the first digit enable appears one cycle later, as described below.

## Timing
- Cycle after reset release: `en_out` selects digit 0, and `out7` shows the glyph of `disp[3:0]` (0 → "0").
- Digit dwell: exactly REFRESH_DIV cycles. A full frame is DIGITS·REFRESH_DIV cycles.
- `out7` and `en_out` change together, one cycle after the terminal count. No cycle ever has two digits enabled.
- `FrameTick` is high in the same cycle that `en_out` first selects digit 0 of a new frame.
- `Load`→display latency: at most one frame plus one cycle. It is exactly one cycle when `Load` coincides with the frame boundary.
- `Value` is sampled only in the `Load` cycle. Changes at other times have no effect.

## Configuration
- `SEG7_SCAN_LZB_EN` defined: leading-zero blanking is on.
  - Every zero nibble above the highest non-zero nibble of `disp` is blanked: all segments off, but the digit enable is still driven.
  - Digit 0 is never blanked.
  - The blank mask is computed combinationally from `disp` and takes effect with `disp`.
- Macro undefined: every digit shows its glyph, including leading zeros. The blanking logic is not synthesised.

## Structure
- Shared package `seg7_pkg` holds:
  - the segment glyph constants `SEG_0`..`SEG_F` and `SEG_BLANK`, active-high;
  - the `{g..a}` bit-index constants.
- Sub-module `seg7_hex_decode`: purely combinational, 4-bit nibble plus blank input to 7-bit active-high segments.
- Polarity inversion, scanning, the capture path and LZB live in `seg7_scan_driver`.

## Test plan
All scenarios use DIGITS=4 and REFRESH_DIV=4 unless stated otherwise.

- **Reset.** Hold `Reset`=0 for 3 cycles, then release.
  - During reset: `out7`=7'h7F, `en_out`=4'hF.
  - First cycle after release: `en_out`=4'hE and `out7`=7'h40 ("0").
- **Scan order.** Run freely after reset.
  - `en_out` cycles E→D→B→7→E, each pattern held exactly 4 cycles.
  - `FrameTick` pulses every 16 cycles, aligned with `en_out`=E.
- **Frame-synchronous load.** Pulse `Load` with `Value`=16'h12AF while digit 2 is active.
  - Display stays 0000 until the next `FrameTick`.
  - Then digit 0 shows 7'h0E ("F") and digit 3 shows 7'h79 ("1").
- **Simultaneous and back-to-back loads.**
  - `Load` on the frame-boundary cycle with 16'h0005: digit 0 shows 7'h12 in the very next cycle.
  - Two `Load` strobes in one frame (16'h1111, then 16'h2222): only 2222 is ever displayed.
- **Mid-frame reset.** Assert `Reset` during digit 1 after loading 16'hBEEF.
  - Outputs go to the off state asynchronously, in the same cycle.
  - After release: `disp`=0 and the scan restarts at digit 0.
- **LZB (macro defined).** Load 16'h0030.
  - Digits 3 and 2 show 7'h7F (blank) with their enables still asserted.
  - Digit 1 shows 7'h30 ("3").
  - Digit 0 shows 7'h40 ("0").
